// File: rtl/trace_checker.sv
// trace_checker: parses ASCII CPU trace records (register or memory writes),
// range-checks time, PC, register index and address, and counts records.
module trace_checker #(
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_4fff,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
  parameter int          GRF_NUM     = 32,
  parameter int          TIME_DIGITS = 4,
  parameter bit          ALLOW_UPPER = 1'b0,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic             char_valid,
  input  logic [15:0]      freq,
  output logic [1:0]       format_type,
  output logic [3:0]       error_code,
  output logic             rec_valid,
  output logic [CNT_W-1:0] rec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [3:0] {
    IDLE, CARET, TIME, AT, PC, COLON, PREFIX, NUM, BLANK, LT, EQ, HEX, DONE
  } state_t;

  localparam logic [3:0] TD = 4'(TIME_DIGITS);

  state_t            r_state, w_state_next;
  logic [31:0]       r_acc, w_acc_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [3:0]        r_err, w_err_next;
  logic [1:0]        r_type, w_type_next;
  logic [1:0]        r_format_type;
  logic [3:0]        r_error_code;
  logic              r_rec_valid;
  logic [CNT_W-1:0]  r_rec_cnt, r_err_cnt;

  logic        w_is_dec, w_is_hex, w_is_reg, w_bad, w_enter_done;
  logic [3:0]  w_dec_val, w_hex_val, w_cnt_inc;
  logic [31:0] w_acc_dec, w_acc_hex, w_tmask;
  logic        w_time_bad, w_pc_bad, w_addr_bad, w_grf_bad;

  always_comb begin
    w_is_dec  = (char >= "0") && (char <= "9");
    w_dec_val = char[3:0];
    w_is_hex  = w_is_dec;
    w_hex_val = char[3:0];
    // Letters 'a'/'A' carry 1 in their low nibble, so +9 yields 10..15.
    if (char >= "a" && char <= "f") begin
      w_is_hex  = 1'b1;
      w_hex_val = char[3:0] + 4'd9;
    end else if (ALLOW_UPPER && char >= "A" && char <= "F") begin
      w_is_hex  = 1'b1;
      w_hex_val = char[3:0] + 4'd9;
    end
  end

  assign w_acc_dec  = r_acc * 32'd10 + {28'd0, w_dec_val};
  assign w_acc_hex  = {r_acc[27:0], w_hex_val};
  assign w_cnt_inc  = r_cnt + 4'd1;
  assign w_tmask    = {16'd0, (freq >> 1) - 16'd1};
  assign w_time_bad = (r_acc & w_tmask) != 32'd0;
  assign w_pc_bad   = (r_acc < PC_LO) || (r_acc > PC_HI) || (r_acc[1:0] != 2'b00);
  assign w_addr_bad = (r_acc > ADDR_HI) || (r_acc[1:0] != 2'b00);
  assign w_grf_bad  = r_acc >= 32'(GRF_NUM);
  assign w_is_reg   = (r_type == 2'b01);

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_type_next  = r_type;
    w_bad        = 1'b0;
    if (char_valid) begin
      if (char == "^") begin
        // '^' always restarts a record, whatever state we were in.
        w_state_next = CARET;
        w_acc_next   = '0;
        w_cnt_next   = '0;
        w_err_next   = '0;
        w_type_next  = '0;
      end else begin
        case (r_state)
          CARET:
            if (w_is_dec) begin
              w_state_next = TIME;
              w_acc_next   = {28'd0, w_dec_val};
              w_cnt_next   = 4'd1;
            end else w_bad = 1'b1;
          TIME:
            if (w_is_dec && r_cnt < TD) begin
              w_acc_next = w_acc_dec;
              w_cnt_next = w_cnt_inc;
            end else if (char == "@") begin
              w_state_next  = AT;
              w_err_next[0] = r_err[0] | w_time_bad;
              w_acc_next    = '0;
              w_cnt_next    = '0;
            end else w_bad = 1'b1;
          AT:
            if (w_is_hex) begin
              w_state_next = PC;
              w_acc_next   = {28'd0, w_hex_val};
              w_cnt_next   = 4'd1;
            end else w_bad = 1'b1;
          PC:
            if (w_is_hex && r_cnt < 4'd8) begin
              w_acc_next = w_acc_hex;
              w_cnt_next = w_cnt_inc;
            end else if (char == ":" && r_cnt == 4'd8) begin
              w_state_next  = COLON;
              w_err_next[1] = r_err[1] | w_pc_bad;
              w_acc_next    = '0;
              w_cnt_next    = '0;
            end else w_bad = 1'b1;
          COLON:
            if (char == "$" || char == "*") begin
              w_state_next = PREFIX;
              w_type_next  = (char == "$") ? 2'b01 : 2'b10;
            end else if (char != " ") w_bad = 1'b1;
          PREFIX:
            if (w_is_reg ? w_is_dec : w_is_hex) begin
              w_state_next = NUM;
              w_acc_next   = {28'd0, w_is_reg ? w_dec_val : w_hex_val};
              w_cnt_next   = 4'd1;
            end else w_bad = 1'b1;
          NUM:
            if (w_is_reg ? (w_is_dec && r_cnt < TD) : (w_is_hex && r_cnt < 4'd8)) begin
              w_acc_next = w_is_reg ? w_acc_dec : w_acc_hex;
              w_cnt_next = w_cnt_inc;
            end else if ((char == " " || char == "<") && (w_is_reg || r_cnt == 4'd8)) begin
              w_state_next = (char == " ") ? BLANK : LT;
              if (w_is_reg) w_err_next[3] = r_err[3] | w_grf_bad;
              else          w_err_next[2] = r_err[2] | w_addr_bad;
              w_acc_next = '0;
              w_cnt_next = '0;
            end else w_bad = 1'b1;
          BLANK:
            if (char == "<") w_state_next = LT;
            else if (char != " ") w_bad = 1'b1;
          LT:
            if (char == "=") w_state_next = EQ;
            else w_bad = 1'b1;
          EQ:
            if (w_is_hex) begin
              w_state_next = HEX;
              w_acc_next   = {28'd0, w_hex_val};
              w_cnt_next   = 4'd1;
            end else if (char != " ") w_bad = 1'b1;
          HEX:
            if (w_is_hex && r_cnt < 4'd8) begin
              w_acc_next = w_acc_hex;
              w_cnt_next = w_cnt_inc;
            end else if (char == "#" && r_cnt == 4'd8) begin
              w_state_next = DONE;
            end else w_bad = 1'b1;
          default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
          w_state_next = IDLE;
          w_acc_next   = '0;
          w_cnt_next   = '0;
          w_err_next   = '0;
          w_type_next  = '0;
        end
      end
    end
  end

  assign w_enter_done = (w_state_next == DONE) && (r_state != DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_err         <= '0;
      r_type        <= '0;
      r_format_type <= '0;
      r_error_code  <= '0;
      r_rec_valid   <= 1'b0;
      r_rec_cnt     <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_acc         <= w_acc_next;
      r_cnt         <= w_cnt_next;
      r_err         <= w_err_next;
      r_type        <= w_type_next;
      r_format_type <= (w_state_next == DONE) ? w_type_next : 2'b00;
      r_error_code  <= (w_state_next == DONE) ? w_err_next : 4'b0000;
      r_rec_valid   <= w_enter_done;
      if (w_enter_done) begin
        if (r_rec_cnt != '1) r_rec_cnt <= r_rec_cnt + CNT_W'(1);
        if (w_err_next != 4'd0 && r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign format_type = r_format_type;
  assign error_code  = r_error_code;
  assign rec_valid   = r_rec_valid;
  assign rec_cnt     = r_rec_cnt;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_trace_checker.sv
// Scoreboard bench for trace_checker: two instances (default, and GRF_NUM=64 /
// CNT_W=2) share one character stream; monitors pop expected records.
module tb_trace_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ch;
  logic        ch_valid;
  logic [15:0] freq;

  logic [1:0]  fmt0, fmt1;
  logic [3:0]  err0, err1;
  logic        rv0, rv1;
  logic [15:0] rc0, ec0;
  logic [1:0]  rc1, ec1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { int fmt; int err; int rc; int ec; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  bit   prev0 = 1'b0;
  bit   prev1 = 1'b0;

  always #5 clk = ~clk;

  trace_checker dut0 (
    .clk(clk), .reset(rst_n), .char(ch), .char_valid(ch_valid), .freq(freq),
    .format_type(fmt0), .error_code(err0), .rec_valid(rv0), .rec_cnt(rc0), .err_cnt(ec0)
  );

  trace_checker #(.GRF_NUM(64), .CNT_W(2)) dut1 (
    .clk(clk), .reset(rst_n), .char(ch), .char_valid(ch_valid), .freq(freq),
    .format_type(fmt1), .error_code(err1), .rec_valid(rv1), .rec_cnt(rc1), .err_cnt(ec1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_rec(input int fmt, input int e0, input int r0, input int c0,
                            input int e1, input int r1, input int c1);
    exp_t a, b;
    a = '{fmt, e0, r0, c0};
    b = '{fmt, e1, r1, c1};
    q0.push_back(a);
    q1.push_back(b);
  endtask

  task automatic send(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          ch_valid = 1'b0;
          @(posedge clk); #1;
        end
      ch = s[i];
      ch_valid = 1'b1;
      @(posedge clk); #1;
    end
    ch_valid = 1'b0;
    $display("sent \"%s\"", s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (prev0) chk("dut0 rec_valid width", int'(rv0), 0);
    prev0 = rv0;
    if (rv0) begin
      if (q0.size() == 0) chk("dut0 unexpected rec_valid", int'(rv0), 0);
      else begin
        e = q0.pop_front();
        $display("dut0 record fmt=%0d err=%b rec_cnt=%0d err_cnt=%0d", fmt0, err0, rc0, ec0);
        chk("dut0 format_type", int'(fmt0), e.fmt);
        chk("dut0 error_code", int'(err0), e.err);
        chk("dut0 rec_cnt", int'(rc0), e.rc);
        chk("dut0 err_cnt", int'(ec0), e.ec);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (prev1) chk("dut1 rec_valid width", int'(rv1), 0);
    prev1 = rv1;
    if (rv1) begin
      if (q1.size() == 0) chk("dut1 unexpected rec_valid", int'(rv1), 0);
      else begin
        e = q1.pop_front();
        $display("dut1 record fmt=%0d err=%b rec_cnt=%0d err_cnt=%0d", fmt1, err1, rc1, ec1);
        chk("dut1 format_type", int'(fmt1), e.fmt);
        chk("dut1 error_code", int'(err1), e.err);
        chk("dut1 rec_cnt", int'(rc1), e.rc);
        chk("dut1 err_cnt", int'(ec1), e.ec);
      end
    end
  end

  initial begin
    string good;
    good = "^10@00003000: $1 <= 00000001#";
    rst_n = 1'b0; ch = 8'h00; ch_valid = 1'b0; freq = 16'd4;
    idle(3);
    chk("reset format_type", int'(fmt0), 0);
    chk("reset error_code", int'(err0), 0);
    chk("reset rec_valid", int'(rv0), 0);
    chk("reset rec_cnt", int'(rc0), 0);
    chk("reset err_cnt", int'(ec0), 0);
    rst_n = 1'b1;
    idle(1);

    // Basic register and memory records, grf boundary at 32 vs 64.
    expect_rec(1, 0, 1, 0, 0, 1, 0);
    send(good, 1'b0);
    idle(3);
    chk("done hold format_type", int'(fmt0), 1);
    chk("done hold rec_valid", int'(rv0), 0);
    expect_rec(2, 7, 2, 1, 7, 2, 1);
    send("^11@00003002:*00003000<=0000abcd#", 1'b0);
    expect_rec(1, 8, 3, 2, 0, 3, 1);
    send("^12@00003004:$32<=00000000#", 1'b0);
    idle(3);

    // Resynchronisation on '^', with and without char_valid gaps.
    rst_n = 1'b0; #2; rst_n = 1'b1;
    idle(1);
    expect_rec(1, 0, 1, 0, 0, 1, 0);
    send("^1@0000300^2@00003000:$0<=00000000#", 1'b0);
    expect_rec(1, 0, 2, 0, 0, 2, 0);
    send("^1@0000300^2@00003000:$0<=00000000#", 1'b1);
    idle(2);

    // Illegal streams: no record, outputs stay 0.
    send("^13@00003000:$1<=0000ABCD#", 1'b0);
    send("^10@00003000:$1<=000000001#", 1'b0);
    send("^10000@00003000:$1<=00000001#", 1'b0);
    idle(3);
    chk("illegal format_type", int'(fmt0), 0);
    chk("illegal error_code", int'(err0), 0);
    chk("illegal rec_cnt", int'(rc0), 2);

    // Back-to-back records, then a different freq mask.
    expect_rec(1, 0, 3, 0, 0, 3, 0);
    expect_rec(2, 1, 4, 1, 1, 3, 1);
    send("^10@00003000:$1<=00000001#^11@00004ffc:*00002ffc<=12345678#", 1'b0);
    freq = 16'd16;
    expect_rec(1, 0, 5, 1, 0, 3, 1);
    send("^24@00003000:$1<=00000001#", 1'b0);
    expect_rec(1, 1, 6, 2, 1, 3, 2);
    send("^12@00003000:$1<=00000001#", 1'b0);
    freq = 16'd4;
    idle(2);

    // Reset asserted while in DONE clears outputs without a clock edge.
    chk("pre-reset format_type", int'(fmt0), 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async reset format_type", int'(fmt0), 0);
    chk("async reset error_code", int'(err0), 0);
    chk("async reset rec_cnt", int'(rc0), 0);
    chk("async reset err_cnt", int'(ec0), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Saturation of the 2-bit counters in dut1.
    for (int i = 1; i <= 5; i++) begin
      expect_rec(1, 0, i, 0, 0, (i > 3) ? 3 : i, 0);
      send(good, 1'b0);
    end
    for (int i = 1; i <= 4; i++) begin
      expect_rec(1, 1, 5 + i, i, 1, 3, (i > 3) ? 3 : i);
      send("^11@00003000:$1<=00000001#", 1'b0);
    end
    idle(3);
    chk("saturated rec_cnt", int'(rc1), 3);
    chk("saturated err_cnt", int'(ec1), 3);
    chk("unsaturated rec_cnt", int'(rc0), 9);
    chk("dut0 records outstanding", q0.size(), 0);
    chk("dut1 records outstanding", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
